// File: rtl/lsu_dmem_if.sv
`default_nettype none
// ============================================================================
//  Module      : ace_if
//  Description : ACE link between the LSU (master) and its data memory
//                (slave). Carries the AR/R, AW/W/B read/write channels, the
//                AC/CR/CD snoop channels and the rack/wack acknowledges.
//                ACE_XDATA_WIDTH is the block size in bits; ACE_AXADDR_WIDTH
//                is the byte-address width.
//  Modports    : m - LSU side, drives requests, snoop responses, acks
//                s - memory side, drives readies, R/B responses, snoops
//  Revision    : 1.0 - initial release
// ============================================================================
interface ace_if #(
    parameter int ACE_XDATA_WIDTH  = 128,
    parameter int ACE_AXADDR_WIDTH = 32,
    parameter int ACE_ID_WIDTH     = 4
);
    // Read address
    logic                          arvalid;
    logic                          arready;
    logic [ACE_AXADDR_WIDTH-1:0]   araddr;
    logic [7:0]                    arlen;
    logic [2:0]                    arsize;
    logic [1:0]                    arburst;
    // Read data
    logic                          rvalid;
    logic                          rready;
    logic [ACE_XDATA_WIDTH-1:0]    rdata;
    logic [3:0]                    rresp;
    logic                          rlast;
    logic [ACE_ID_WIDTH-1:0]       rid;
    // Write address
    logic                          awvalid;
    logic                          awready;
    logic [ACE_AXADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                    awlen;
    logic [2:0]                    awsize;
    logic [1:0]                    awburst;
    // Write data
    logic                          wvalid;
    logic                          wready;
    logic [ACE_XDATA_WIDTH-1:0]    wdata;
    logic [ACE_XDATA_WIDTH/8-1:0]  wstrb;
    logic                          wlast;
    // Write response
    logic                          bvalid;
    logic                          bready;
    logic [1:0]                    bresp;
    logic [ACE_ID_WIDTH-1:0]       bid;
    // Snoop address
    logic                          acvalid;
    logic                          acready;
    logic [ACE_AXADDR_WIDTH-1:0]   acaddr;
    logic [3:0]                    acsnoop;
    logic [2:0]                    acprot;
    // Snoop response / data
    logic                          crvalid;
    logic                          crready;
    logic [4:0]                    crresp;
    logic                          cdvalid;
    logic                          cdready;
    logic [ACE_XDATA_WIDTH-1:0]    cddata;
    logic                          cdlast;
    // Read / write acknowledge
    logic                          rack;
    logic                          wack;

    modport m (
        output arvalid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready,
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        input  acvalid, acaddr, acsnoop, acprot,
        output acready,
        output crvalid, crresp,
        input  crready,
        output cdvalid, cddata, cdlast,
        input  cdready,
        output rack, wack
    );

    modport s (
        input  arvalid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready,
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        output acvalid, acaddr, acsnoop, acprot,
        input  acready,
        input  crvalid, crresp,
        output crready,
        input  cdvalid, cddata, cdlast,
        output cdready,
        input  rack, wack
    );
endinterface
`default_nettype wire

// File: rtl/lsu_dmem.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_dmem
//  Description : Single-port block data memory behind the LSU ACE port.
//                Serves single-beat full-block reads and byte-strobed
//                writes, one transaction at a time. Snoop channels inert.
//  Ports       : clk   - clock
//                rst   - synchronous active-high reset
//                s_ace - ace_if slave; block size = ACE_XDATA_WIDTH
//  Parameters  : DEPTH        - blocks stored (power of two)
//                READ_LATENCY - AR accept to read-data capture, 1..15
//                INIT_FILE    - initial image name; contents start at zero
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_dmem #(
    parameter int    DEPTH        = 256,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  wire logic clk,
    input  wire logic rst,
    ace_if.s          s_ace
);
    localparam int c_XW  = $bits(s_ace.wdata);
    localparam int c_AW  = $bits(s_ace.araddr);
    localparam int c_NB  = c_XW / 8;
    localparam int c_OFF = $clog2(c_NB);
    localparam int c_IW  = $clog2(DEPTH);
    localparam int c_BW  = c_AW - c_OFF;   // block-address width

    localparam logic [3:0] c_CNT_INIT = 4'(READ_LATENCY - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_RD_WAIT   = 3'd1;
    localparam logic [2:0] c_R_RESP    = 3'd2;
    localparam logic [2:0] c_W_COLLECT = 3'd3;
    localparam logic [2:0] c_B_RESP    = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [3:0]      r_cnt;
    logic [c_BW-1:0] r_blk;
    logic [c_XW-1:0] r_wdata;
    logic [c_NB-1:0] r_wstrb;
    logic            r_w_held;
    logic [c_XW-1:0] r_rdata;
    logic [1:0]      r_rresp;
    logic [1:0]      r_bresp;
    logic            r_last_wr;

    logic [c_XW-1:0] r_mem [DEPTH] = '{default: '0};

    logic            w_grant_rd;
    logic            w_grant_wr;
    logic [c_IW-1:0] w_idx;
    logic            w_oor;
    logic            w_mem_we;
    logic            w_arready;
    logic            w_awready;
    logic            w_wready;
    logic            w_rvalid;
    logic            w_bvalid;

    // Read wins when alone, or on a tie when the previous grant was a write.
    assign w_grant_rd = s_ace.arvalid && (!s_ace.awvalid || r_last_wr);
    assign w_grant_wr = s_ace.awvalid && !w_grant_rd;

    assign w_idx    = r_blk[c_IW-1:0];
    assign w_oor    = (r_blk >> c_IW) != '0;
    assign w_mem_we = !rst && (r_state == c_W_COLLECT) && r_w_held && !w_oor;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_blk     <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_w_held  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
            r_bresp   <= 2'b00;
            r_last_wr <= 1'b1;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_rd) begin
                        r_blk     <= s_ace.araddr[c_AW-1:c_OFF];
                        r_cnt     <= c_CNT_INIT;
                        r_last_wr <= 1'b0;
                    end else if (w_grant_wr) begin
                        r_blk     <= s_ace.awaddr[c_AW-1:c_OFF];
                        r_last_wr <= 1'b1;
                        r_w_held  <= s_ace.wvalid;
                        if (s_ace.wvalid) begin
                            r_wdata <= s_ace.wdata;
                            r_wstrb <= s_ace.wstrb;
                        end
                    end
                end
                c_RD_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rdata <= w_oor ? '0 : r_mem[w_idx];
                        r_rresp <= w_oor ? 2'b11 : 2'b00;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_W_COLLECT: begin
                    if (!r_w_held) begin
                        if (s_ace.wvalid) begin
                            r_wdata  <= s_ace.wdata;
                            r_wstrb  <= s_ace.wstrb;
                            r_w_held <= 1'b1;
                        end
                    end else begin
                        r_bresp  <= w_oor ? 2'b11 : 2'b00;
                        r_w_held <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte-enable write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < c_NB; i++) begin
                if (r_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_rd) begin
                    w_next = c_RD_WAIT;
                end else if (w_grant_wr) begin
                    w_next = c_W_COLLECT;
                end
            end
            c_RD_WAIT:   if (r_cnt == 4'd0) w_next = c_R_RESP;
            c_R_RESP:    if (s_ace.rready)  w_next = c_IDLE;
            c_W_COLLECT: if (r_w_held)      w_next = c_B_RESP;
            c_B_RESP:    if (s_ace.bready)  w_next = c_IDLE;
            default:     w_next = c_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Readies depend only on state and the incoming valids, never on our own
    // valids, so no combinational loop can form through the link.
    always_comb begin
        w_arready = 1'b0;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_rvalid  = 1'b0;
        w_bvalid  = 1'b0;
        if (!rst) begin
            case (r_state)
                c_IDLE: begin
                    w_arready = w_grant_rd;
                    w_awready = w_grant_wr;
                    w_wready  = w_grant_wr && s_ace.wvalid;
                end
                c_W_COLLECT: w_wready = !r_w_held;
                c_R_RESP:    w_rvalid = 1'b1;
                c_B_RESP:    w_bvalid = 1'b1;
                default: ;
            endcase
        end
    end

    assign s_ace.arready = w_arready;
    assign s_ace.awready = w_awready;
    assign s_ace.wready  = w_wready;
    assign s_ace.rvalid  = w_rvalid;
    assign s_ace.rdata   = r_rdata;
    assign s_ace.rresp   = {2'b00, r_rresp};
    assign s_ace.rlast   = w_rvalid;
    assign s_ace.rid     = '0;
    assign s_ace.bvalid  = w_bvalid;
    assign s_ace.bresp   = r_bresp;
    assign s_ace.bid     = '0;

    // Inert snoop slave.
    assign s_ace.acvalid = 1'b0;
    assign s_ace.acaddr  = '0;
    assign s_ace.acsnoop = 4'd0;
    assign s_ace.acprot  = 3'd0;
    assign s_ace.crready = 1'b1;
    assign s_ace.cdready = 1'b1;

    // Only single-beat transfers are served.
    always_ff @(posedge clk) begin
        if (!rst && w_arready) assert (s_ace.arlen == 8'd0);
        if (!rst && w_awready) assert (s_ace.awlen == 8'd0);
    end
endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_dmem
//  Description : Directed self-checking bench for lsu_dmem.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_dmem;
    localparam int c_XW   = 128;
    localparam int c_AW   = 32;
    localparam int c_RL   = 2;
    localparam int c_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [c_XW-1:0] d0, d1, d2, da5, dbyte, ebyte;

    always #5 clk = ~clk;

    ace_if #(.ACE_XDATA_WIDTH(c_XW), .ACE_AXADDR_WIDTH(c_AW)) bus ();

    lsu_dmem #(
        .DEPTH(256),
        .READ_LATENCY(c_RL),
        .INIT_FILE("")
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_ace(bus.s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [c_XW-1:0] obs, input logic [c_XW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_read(input string tag, input logic [c_AW-1:0] addr);
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        #1;
        check({tag, " arready"}, bus.arready, 1);
        tick();
        bus.arvalid = 1'b0;
    endtask

    // Called in the cycle after AR acceptance.
    task automatic finish_read(input string tag, input logic [c_XW-1:0] ed, input logic [1:0] er, input int hold);
        for (int i = 0; i < c_RL; i++) begin
            check({tag, " rvalid early"}, bus.rvalid, 0);
            tick();
        end
        check({tag, " rvalid"}, bus.rvalid, 1);
        check({tag, " rdata"}, bus.rdata, ed);
        check({tag, " rresp"}, bus.rresp, {2'b00, er});
        check({tag, " rlast"}, bus.rlast, 1);
        for (int h = 0; h < hold; h++) begin
            bus.arvalid = 1'b1;
            #1;
            check({tag, " ar blocked"}, bus.arready, 0);
            tick();
            check({tag, " rvalid held"}, bus.rvalid, 1);
            check({tag, " rdata held"}, bus.rdata, ed);
        end
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        tick();
        bus.rready  = 1'b0;
        check({tag, " rvalid drop"}, bus.rvalid, 0);
    endtask

    task automatic start_write(input string tag, input logic [c_AW-1:0] addr,
                               input logic [c_XW-1:0] data, input logic [c_XW/8-1:0] strb);
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        bus.wvalid  = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        #1;
        check({tag, " awready"}, bus.awready, 1);
        check({tag, " wready"}, bus.wready, 1);
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    // Called in the cycle after the AW+W handshake.
    task automatic finish_write(input string tag, input logic [1:0] er, input int hold);
        check({tag, " bvalid early"}, bus.bvalid, 0);
        tick();
        check({tag, " bvalid"}, bus.bvalid, 1);
        check({tag, " bresp"}, bus.bresp, er);
        for (int h = 0; h < hold; h++) begin
            bus.awvalid = 1'b1;
            #1;
            check({tag, " aw blocked"}, bus.awready, 0);
            tick();
            check({tag, " bvalid held"}, bus.bvalid, 1);
            check({tag, " bresp held"}, bus.bresp, er);
        end
        bus.awvalid = 1'b0;
        bus.bready  = 1'b1;
        tick();
        bus.bready  = 1'b0;
        check({tag, " bvalid drop"}, bus.bvalid, 0);
    endtask

    initial begin
        bus.arvalid = 0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd4; bus.arburst = 2'b01;
        bus.rready  = 0;
        bus.awvalid = 0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd4; bus.awburst = 2'b01;
        bus.wvalid  = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b1;
        bus.bready  = 0;
        bus.acready = 0; bus.crvalid = 0; bus.crresp = '0;
        bus.cdvalid = 0; bus.cddata = '0; bus.cdlast = 0;
        bus.rack    = 0; bus.wack = 0;

        d0  = {16{8'h5A}};
        d1  = {16{8'h3C}};
        d2  = {16{8'hC3}};
        da5 = {16{8'hA5}};
        ebyte = 128'h7E << 40;
        dbyte = ({16{8'hFF}} & ~(128'hFF << 40)) | ebyte;

        // ---- reset state, with requests presented during reset
        repeat (2) tick();
        bus.arvalid = 1'b1;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        #1;
        check("rst arready", bus.arready, 0);
        check("rst awready", bus.awready, 0);
        check("rst wready",  bus.wready, 0);
        check("rst rvalid",  bus.rvalid, 0);
        check("rst bvalid",  bus.bvalid, 0);
        check("rst rdata",   bus.rdata, 0);
        check("rst rresp",   bus.rresp, 0);
        check("rst bresp",   bus.bresp, 0);
        check("tie acvalid", bus.acvalid, 0);
        check("tie acaddr",  bus.acaddr, 0);
        check("tie acsnoop", bus.acsnoop, 0);
        check("tie crready", bus.crready, 1);
        check("tie cdready", bus.cdready, 1);
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        rst = 1'b0;
        tick();

        // ---- preload, then reset again so last-grant returns to write
        start_write("pre", 32'h80, d0, 16'hFFFF);
        finish_write("pre", 2'b00, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // ---- simultaneous AR/AW twice: read first, then write
        bus.arvalid = 1'b1; bus.araddr = 32'h80;
        bus.awvalid = 1'b1; bus.awaddr = 32'h90;
        bus.wvalid  = 1'b1; bus.wdata  = d1; bus.wstrb = 16'hFFFF;
        #1;
        check("arb1 arready", bus.arready, 1);
        check("arb1 awready", bus.awready, 0);
        check("arb1 wready",  bus.wready, 0);
        tick();
        bus.arvalid = 1'b0;
        finish_read("arb1 rd", d0, 2'b00, 0);
        bus.arvalid = 1'b1;
        #1;
        check("arb2 arready", bus.arready, 0);
        check("arb2 awready", bus.awready, 1);
        check("arb2 wready",  bus.wready, 1);
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("arb2 ar blocked", bus.arready, 0);
        bus.arvalid = 1'b0;
        finish_write("arb2 wr", 2'b00, 0);
        start_read("raw", 32'h90);
        finish_read("raw", d1, 2'b00, 0);

        // ---- write then read
        start_write("wr40", 32'h40, da5, 16'hFFFF);
        finish_write("wr40", 2'b00, 0);
        start_read("rd40", 32'h40);
        finish_read("rd40", da5, 2'b00, 0);

        // ---- byte strobes
        start_write("zero0", 32'h0, '0, 16'hFFFF);
        finish_write("zero0", 2'b00, 0);
        start_write("strb5", 32'h0, dbyte, 16'h0020);
        finish_write("strb5", 2'b00, 0);
        start_read("rdstrb", 32'h0);
        finish_read("rdstrb", ebyte, 2'b00, 0);

        // ---- split AW / W: AW cycle 0, W cycle 3, bvalid cycle 5
        bus.awvalid = 1'b1; bus.awaddr = 32'h50;
        #1;
        check("split awready c0", bus.awready, 1);
        check("split wready c0",  bus.wready, 0);
        tick();
        bus.awvalid = 1'b0;
        check("split bvalid c1", bus.bvalid, 0);
        tick();
        check("split bvalid c2", bus.bvalid, 0);
        tick();
        bus.wvalid = 1'b1; bus.wdata = d2; bus.wstrb = 16'hFFFF;
        #1;
        check("split wready c3", bus.wready, 1);
        tick();
        bus.wvalid = 1'b0;
        check("split bvalid c4", bus.bvalid, 0);
        check("split wready c4", bus.wready, 0);
        tick();
        check("split bvalid c5", bus.bvalid, 1);
        check("split bresp c5",  bus.bresp, 0);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        start_read("rd50", 32'h50);
        finish_read("rd50", d2, 2'b00, 0);

        // ---- wvalid alone in IDLE is not accepted
        bus.wvalid = 1'b1; bus.wdata = d0;
        #1;
        check("wonly wready", bus.wready, 0);
        tick();
        check("wonly wready2", bus.wready, 0);
        check("wonly bvalid", bus.bvalid, 0);
        bus.wvalid = 1'b0;

        // ---- backpressure on R and B
        start_read("bp rd", 32'h40);
        finish_read("bp rd", da5, 2'b00, c_HOLD);
        start_write("bp wr", 32'h60, d2, 16'hFFFF);
        finish_write("bp wr", 2'b00, c_HOLD);

        // ---- empty strobe changes nothing
        start_write("strb0", 32'h60, '0, 16'h0000);
        finish_write("strb0", 2'b00, 0);
        start_read("rd60", 32'h60);
        finish_read("rd60", d2, 2'b00, 0);

        // ---- out of range (aliases index 0 if decoded wrongly)
        start_read("oor rd", 32'h1000);
        finish_read("oor rd", '0, 2'b11, 0);
        start_write("oor wr", 32'h1000, {16{8'h33}}, 16'hFFFF);
        finish_write("oor wr", 2'b11, 0);
        start_read("rd0 after oor", 32'h0);
        finish_read("rd0 after oor", ebyte, 2'b00, 0);

        // ---- reset during RD_WAIT
        start_read("rstrd", 32'h40);
        rst = 1'b1;
        #1;
        check("rstrd rvalid in rst", bus.rvalid, 0);
        tick();
        check("rstrd rvalid", bus.rvalid, 0);
        check("rstrd rdata",  bus.rdata, 0);
        check("rstrd arready", bus.arready, 0);
        check("rstrd bvalid", bus.bvalid, 0);
        rst = 1'b0;
        tick();
        check("rstrd no resp1", bus.rvalid, 0);
        tick();
        check("rstrd no resp2", bus.rvalid, 0);

        // ---- reset in W_COLLECT after AW, before W
        bus.awvalid = 1'b1; bus.awaddr = 32'h40;
        #1;
        check("rstwr awready", bus.awready, 1);
        tick();
        bus.awvalid = 1'b0;
        check("rstwr collecting", bus.wready, 1);
        rst = 1'b1;
        tick();
        check("rstwr wready",  bus.wready, 0);
        check("rstwr awready0", bus.awready, 0);
        check("rstwr bvalid",  bus.bvalid, 0);
        check("rstwr rvalid",  bus.rvalid, 0);
        rst = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = {16{8'hEE}}; bus.wstrb = 16'hFFFF;
        #1;
        check("rstwr stale w", bus.wready, 0);
        tick();
        bus.wvalid = 1'b0;
        check("rstwr no b1", bus.bvalid, 0);
        tick();
        check("rstwr no b2", bus.bvalid, 0);
        start_read("rd40 after rst", 32'h40);
        finish_read("rd40 after rst", da5, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
